// File: rtl/p2018_pkg.sv
// Shared definitions for the emulated detector pulse source and its consumers:
// default widths, state encodings and the decay / saturating-add arithmetic.
package p2018_pkg;

  localparam int P2018_WIDTH       = 16;
  localparam int P2018_DECAY_SHIFT = 4;
  localparam int P2018_MAXW        = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } p2018_state_e;

  // One exponential-decay step; small values fall by one so the tail always reaches zero.
  function automatic logic [P2018_MAXW-1:0] decay_step(input logic [P2018_MAXW-1:0] y,
                                                       input int shift);
    logic [P2018_MAXW-1:0] tail;
    tail = y >> shift;
    if (y == '0) return '0;
    if (tail == '0) return y - P2018_MAXW'(1);
    return y - tail;
  endfunction

  function automatic logic [P2018_MAXW-1:0] sat_add(input logic [P2018_MAXW-1:0] a,
                                                    input logic [P2018_MAXW-1:0] b,
                                                    input int width);
    logic [P2018_MAXW:0]   sum;
    logic [P2018_MAXW-1:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (width >= P2018_MAXW) ? '1 : ((P2018_MAXW'(1) << width) - P2018_MAXW'(1));
    return (sum > {1'b0, lim}) ? lim : sum[P2018_MAXW-1:0];
  endfunction

endpackage

// File: rtl/p2018_pulse_gen_period_timer.sv
// Free-running auto-trigger timer: one tick every 'period' enabled cycles, off when period is 0.
module p2018_period_timer
  import p2018_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                auto_tick
);

  logic [PERIOD_W-1:0] count_reg;

  // A >= compare lets a period shortened below the current count tick at once and restart.
  assign auto_tick = enable && (period != '0) && (count_reg >= period - PERIOD_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (enable) begin
      if (period == '0 || auto_tick) count_reg <= '0;
      else                           count_reg <= count_reg + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/p2018_pulse_gen.sv
// Emulated detector front end: exponential-decay pulses with pile-up, holdoff rejection
// and an optional periodic auto-trigger.
module p2018_pulse_gen
  import p2018_pkg::*;
#(
  parameter int WIDTH       = P2018_WIDTH,
  parameter int DECAY_SHIFT = P2018_DECAY_SHIFT,
  parameter int HOLDOFF     = 10,
  parameter int PERIOD_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                trig,
  input  logic [WIDTH-1:0]    amp,
  input  logic [PERIOD_W-1:0] period,
  output logic [WIDTH-1:0]    out,
  output logic                busy,
  output logic                fire,
  output logic [7:0]          rej_cnt
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  p2018_state_e      state_reg;
  logic [WIDTH-1:0]  out_reg;
  logic [HOLD_W-1:0] holdoff_reg;
  logic              fire_reg;
  logic [7:0]        rej_reg;

  logic              auto_tick;
  logic              req;
  logic [WIDTH-1:0]  decayed;
  logic [WIDTH-1:0]  piled;

  p2018_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .period    (period),
    .auto_tick (auto_tick)
  );

  // Manual and auto requests in the same cycle merge into a single pulse.
  assign req     = trig | auto_tick;
  assign decayed = WIDTH'(decay_step(P2018_MAXW'(out_reg), DECAY_SHIFT));
  assign piled   = WIDTH'(sat_add(P2018_MAXW'(decayed), P2018_MAXW'(amp), WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      out_reg     <= '0;
      holdoff_reg <= '0;
      fire_reg    <= 1'b0;
      rej_reg     <= '0;
    end else if (enable) begin
      fire_reg <= 1'b0;
      case (state_reg)
        IDLE, DECAY: begin
          if (req) begin
            out_reg     <= piled;
            fire_reg    <= 1'b1;
            holdoff_reg <= HOLD_W'(HOLDOFF - 1);
            if (HOLDOFF > 1) state_reg <= HOLD;
            else             state_reg <= (piled != '0) ? DECAY : IDLE;
          end else begin
            out_reg   <= decayed;
            state_reg <= (decayed != '0) ? DECAY : IDLE;
          end
        end
        HOLD: begin
          out_reg     <= decayed;
          holdoff_reg <= holdoff_reg - HOLD_W'(1);
          if (req && rej_reg != 8'hFF) rej_reg <= rej_reg + 8'd1;
          if (holdoff_reg == HOLD_W'(1)) state_reg <= (decayed != '0) ? DECAY : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end else begin
      fire_reg <= 1'b0;
    end
  end

  assign out     = out_reg;
  assign busy    = (state_reg != IDLE);
  assign fire    = fire_reg;
  assign rej_cnt = rej_reg;

endmodule

// File: tb/tb_p2018_pulse_gen.sv
// Randomised and directed bench for p2018_pulse_gen against a cycle-level behavioural model.
module tb_p2018_pulse_gen;

  localparam int HOLDOFF = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        trig = 1'b0;
  logic [15:0] amp = '0;
  logic [15:0] period = '0;
  logic [15:0] out;
  logic        busy;
  logic        fire;
  logic [7:0]  rej_cnt;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int m_out, m_rej, m_tmr, m_n, m_last;
  bit m_fire, m_busy;

  p2018_pulse_gen dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .trig    (trig),
    .amp     (amp),
    .period  (period),
    .out     (out),
    .busy    (busy),
    .fire    (fire),
    .rej_cnt (rej_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_decay(input int y);
    if (y == 0) return 0;
    if (y < 16) return y - 1;
    return y - y / 16;
  endfunction

  task automatic model_reset();
    m_out = 0; m_rej = 0; m_tmr = 0; m_n = 0; m_last = -1000;
    m_fire = 0; m_busy = 0;
  endtask

  // One clock edge of the model: holdoff expressed as distance from the last accepted pulse.
  task automatic model_edge();
    bit tick, req, in_hold;
    int d;
    if (!reset) return;
    if (!enable) begin
      m_fire = 0;
      return;
    end
    tick = (period != 0) && (m_tmr >= int'(period) - 1);
    if (period == 0 || tick) m_tmr = 0;
    else m_tmr++;
    req = trig || tick;
    m_n++;
    in_hold = (m_n - m_last) < HOLDOFF;
    d = ref_decay(m_out);
    m_fire = 0;
    if (req && !in_hold) begin
      m_out = (d + int'(amp) > 65535) ? 65535 : d + int'(amp);
      m_fire = 1;
      m_last = m_n;
    end else begin
      m_out = d;
      if (req && m_rej < 255) m_rej++;
    end
    m_busy = ((m_n - m_last) < HOLDOFF - 1) || (m_out != 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("out", int'(out), m_out);
    check("busy", int'(busy), int'(m_busy));
    check("fire", int'(fire), int'(m_fire));
    check("rej_cnt", int'(rej_cnt), m_rej);
    $display("cyc t=%0t en=%0b trig=%0b amp=%0d per=%0d out=%0d busy=%0b fire=%0b rej=%0d",
             $time, enable, trig, amp, period, out, busy, fire, rej_cnt);
  endtask

  task automatic idle_cycles(input int n);
    trig = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int exp1 [5] = '{1000, 938, 880, 825, 774};
    int fire_cnt, rej0, last_fire, gaps, n;
    bit seen;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out", int'(out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fire", int'(fire), 0);
    check("rst_rej", int'(rej_cnt), 0);
    reset = 1;
    idle_cycles(3);

    // 1: single manual pulse and its decay
    amp = 16'd1000; trig = 1;
    cycle();
    trig = 0;
    check("t1_out0", int'(out), exp1[0]);
    check("t1_fire", int'(fire), 1);
    for (int i = 1; i < 5; i++) begin
      cycle();
      check("t1_out", int'(out), exp1[i]);
    end

    // 2: ride the tail down to zero
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cycle();
      if (m_out == 0) begin
        seen = 1;
        check("t2_busy", int'(busy), 0);
      end
    end
    check("t2_reached_zero", int'(seen), 1);

    // 3: pile-up saturates without wrapping
    amp = 16'd60000; trig = 1;
    cycle();
    idle_cycles(10);
    amp = 16'd50000; trig = 1;
    cycle();
    trig = 0;
    check("t3_sat", int'(out), 65535);
    check("t3_fire", int'(fire), 1);
    idle_cycles(12);

    // 4: holdoff rejects the k+3 trigger, accepts k+10
    rej0 = m_rej;
    fire_cnt = 0;
    amp = 16'd300;
    for (int i = 0; i <= 10; i++) begin
      trig = (i == 0 || i == 3 || i == 10);
      cycle();
      if (i < 10 && fire) fire_cnt++;
      if (i == 10) check("t4_fire10", int'(fire), 1);
    end
    trig = 0;
    check("t4_fires", fire_cnt, 1);
    check("t4_rej", int'(rej_cnt), rej0 + 1);

    // 5: auto trigger every 20 cycles
    idle_cycles(12);
    amp = 16'd500; period = 16'd20;
    last_fire = -1; gaps = 0; n = 0;
    for (int i = 0; i < 70; i++) begin
      cycle();
      n++;
      if (fire) begin
        if (last_fire >= 0) begin
          check("t5_gap", n - last_fire, 20);
          gaps++;
        end
        last_fire = n;
      end
    end
    check("t5_gapcount", gaps, 2);
    seen = 0;
    rej0 = m_rej;
    for (int i = 0; i < 25 && !seen; i++) begin
      trig = (m_tmr == 19);
      cycle();
      if (trig) begin
        seen = 1;
        check("t5_coinc_fire", int'(fire), 1);
        check("t5_coinc_rej", int'(rej_cnt), rej0);
      end
    end
    trig = 0;
    check("t5_coinc_seen", int'(seen), 1);

    // randomised phase
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 4))
          0: period = 16'd0;
          1: period = 16'd1;
          2: period = 16'd3;
          3: period = 16'd20;
          default: period = 16'($urandom_range(2, 40));
        endcase
      end
      trig   = ($urandom_range(0, 5) == 0);
      amp    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                           : 16'($urandom_range(0, 2000));
      enable = ($urandom_range(0, 9) != 0);
      cycle();
    end
    enable = 1; trig = 0; period = 0;
    idle_cycles(40);

    // 6: asynchronous reset in the middle of a decay
    amp = 16'd700; trig = 1;
    cycle();
    trig = 0;
    cycle();
    #2;
    reset = 0;
    model_reset();
    #1;
    check("t6_out", int'(out), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_rej", int'(rej_cnt), 0);
    check("t6_fire", int'(fire), 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t6_idle", int'(out), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
